soda_coin_acceptor: RTL and testbench
=====================================

Name: soda_coin_acceptor

Overview:
Front-end coin acceptor that feeds the soda dispenser controller's coin interface. It synchronizes and debounces the raw coin-slot sensor, then classifies each coin from the sensor size code. Accepted coins go into a 2-entry queue, which presents c (coin valid) and a (coin value) to the controller/datapath. A coin is held on c/a until the controller acknowledges it (coin_ack is tied to the controller's tot_ld), so no coin is lost while the controller is in ADD, DISP or INIT.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples that must disagree with the debounced level before it flips (min 1)
VAL_W, 8, width of coin value output a
VAL_NICKEL, 5, value emitted for size code 01
VAL_DIME, 10, value emitted for size code 10
VAL_QUARTER, 25, value emitted for size code 11

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset; synchronous, active-high
sense  in  1  raw coin-slot sensor, asynchronous; high while a coin is in the slot
size_code  in  2  raw coin size class: 00 invalid, 01 nickel, 10 dime, 11 quarter; stable while sense is high
coin_ack  in  1  pop the head coin; one-cycle pulse from the controller's tot_ld
c  out  1  head coin valid (queue non-empty)
a  out  VAL_W  head coin value; 0 when c=0
reject  out  1  one-cycle pulse: coin returned (invalid code or queue full)
fill  out  2  queue occupancy, 0..2

Behaviour:
- Reset (sync): sync flops, debounced level, debounce counter and queue all cleared. c=0, a=0, reject=0, fill=0.
- Reset mid-operation: debounce progress and queued coins are discarded. If sense is still high after reset, that coin is re-debounced and accepted once.
- Synchronizer: 2-flop synchronizer on sense and on size_code (sync2 = second stage).
- Debounce counter:
  - Clears when sync2 sense equals the debounced level.
  - Otherwise increments each cycle.
  - On the edge where it equals DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level takes sync2 and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES synchronized cycles are ignored.
- Coin event: only a debounced 0->1 transition is a coin event, evaluated on the same edge the level flips. A 1->0 transition has no action.
- Latency: raw sense is first sampled high at edge k. The debounced level flips and the enqueue happens at edge k+1+DEBOUNCE_CYCLES. c is high in the following cycle if the queue was empty.
- Classification at a coin event uses sync2 size_code:
  - 01, 10 and 11 map to VAL_NICKEL, VAL_DIME and VAL_QUARTER, zero-extended to VAL_W.
  - 00 gives no enqueue and reject=1 for exactly one cycle.
- Queue: 2 entries, FIFO order.
  - c = (fill != 0); a = head value.
  - coin_ack with c=1 pops the head at that edge. coin_ack with c=0 is ignored.
  - Enqueue and pop in the same cycle: both occur, fill is unchanged, and the new head is the next older entry.
  - Coin event with fill=2 and no pop that cycle: coin dropped, reject pulse for one cycle, queue unchanged.
  - Coin event with fill=2 and a pop that cycle: accepted.
- Handshake with the controller: c stays high and a stays constant until acked. After an ack of the last entry, c is 0 in the next cycle, so the controller back in WAIT does not double-count. With 2 entries queued, c stays high with the new a and the controller adds again.
- reject and a coin event are never generated in the same cycle as each other's cause; at most one coin event per cycle.

Test Plan:
- rst, then sense high for 3 cycles (DEBOUNCE_CYCLES=4) -> c, reject and fill all stay 0.
- size_code=10, sense high for 12 cycles, first sampled at edge 0 -> c=1 and a=10 from the cycle after edge 5, held with no ack; single coin_ack -> c=0, a=0, fill=0 next cycle.
- Three quarters (sense 10 high / 10 low each), no ack -> fill=2, a=25, third coin produces a 1-cycle reject; two acks -> fill 1 then 0.
- size_code=00 with a valid sense pulse -> reject=1 for 1 cycle at the debounce edge, c stays 0.
- fill=1 (nickel queued), dime event on the same edge as coin_ack -> fill stays 1, a changes 5->10.
- fill=2, rst asserted for 1 cycle -> c=0, a=0, fill=0 after that edge; sense held high across reset -> exactly one new coin is accepted after the debounce latency.

Source files
------------

// File: rtl/soda_coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the slot sensor, classifies coins
// and queues up to two of them for the dispenser controller, holding each until acked.
module soda_coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned VAL_W           = 8,
  parameter int unsigned VAL_NICKEL      = 5,
  parameter int unsigned VAL_DIME        = 10,
  parameter int unsigned VAL_QUARTER     = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense,
  input  logic [1:0]       size_code,
  input  logic             coin_ack,
  output logic             c,
  output logic [VAL_W-1:0] a,
  output logic             reject,
  output logic [1:0]       fill
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic             sense_s1_q, sense_s2_q;
  logic [1:0]       code_s1_q, code_s2_q;
  logic             level_q, level_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [VAL_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]       fill_q, fill_d;
  logic             reject_q, reject_d;

  logic             coin_evt;
  logic             pop, push;
  logic [VAL_W-1:0] coin_val;

  // Level flips once sync2 has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    level_d  = level_q;
    cnt_d    = '0;
    coin_evt = 1'b0;
    if (sense_s2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d  = sense_s2_q;
        coin_evt = sense_s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    coin_val = '0;
    case (code_s2_q)
      2'b01:   coin_val = VAL_W'(VAL_NICKEL);
      2'b10:   coin_val = VAL_W'(VAL_DIME);
      2'b11:   coin_val = VAL_W'(VAL_QUARTER);
      default: coin_val = '0;
    endcase
  end

  assign pop      = coin_ack && (fill_q != 2'd0);
  assign push     = coin_evt && (code_s2_q != 2'b00) && ((fill_q != 2'd2) || pop);
  assign reject_d = coin_evt && !push;

  // ent0 is always the head; a pop shifts ent1 forward.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    fill_d = fill_q;
    case ({push, pop})
      2'b01: begin
        ent0_d = ent1_q;
        fill_d = fill_q - 2'd1;
      end
      2'b10: begin
        if (fill_q == 2'd0) ent0_d = coin_val;
        else                ent1_d = coin_val;
        fill_d = fill_q + 2'd1;
      end
      2'b11: begin
        if (fill_q == 2'd1) begin
          ent0_d = coin_val;
        end else begin
          ent0_d = ent1_q;
          ent1_d = coin_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sense_s1_q <= 1'b0;
      sense_s2_q <= 1'b0;
      code_s1_q  <= 2'b00;
      code_s2_q  <= 2'b00;
      level_q    <= 1'b0;
      cnt_q      <= '0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      fill_q     <= 2'd0;
      reject_q   <= 1'b0;
    end else begin
      sense_s1_q <= sense;
      sense_s2_q <= sense_s1_q;
      code_s1_q  <= size_code;
      code_s2_q  <= code_s1_q;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      fill_q     <= fill_d;
      reject_q   <= reject_d;
    end
  end

  assign c      = (fill_q != 2'd0);
  assign a      = c ? ent0_q : '0;
  assign reject = reject_q;
  assign fill   = fill_q;

endmodule

// File: tb/tb_soda_coin_acceptor.sv
// Scoreboard bench for soda_coin_acceptor: directed scenarios followed by random coin traffic,
// checked against a sample-window reference model.
module tb_soda_coin_acceptor;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       rst, sense, coin_ack;
  logic [1:0] size_code;
  logic       c, reject;
  logic [7:0] a;
  logic [1:0] fill;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  always #5 clk = ~clk;

  soda_coin_acceptor #(
    .DEBOUNCE_CYCLES(Deb),
    .VAL_W          (8),
    .VAL_NICKEL     (5),
    .VAL_DIME       (10),
    .VAL_QUARTER    (25)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sense    (sense),
    .size_code(size_code),
    .coin_ack (coin_ack),
    .c        (c),
    .a        (a),
    .reject   (reject),
    .fill     (fill)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int coin_value(input logic [1:0] cd);
    case (cd)
      2'd1:    return 5;
      2'd2:    return 10;
      2'd3:    return 25;
      default: return 0;
    endcase
  endfunction

  // Reference model: raw samples history; a flip needs the last Deb synchronized samples
  // (raw samples two edges old and earlier) to all differ from the current level.
  bit         raw_h[$];
  logic [1:0] code_h[$];
  int         mq[$];
  int         exp_coin_q[$];
  int         exp_rej_q[$];
  bit         mlevel = 0;
  int         edge_n = 0;
  bit         all_diff, s2v, mpop, mfull;
  logic [1:0] code2;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      raw_h.delete();
      code_h.delete();
      mq.delete();
      exp_coin_q.delete();
      exp_rej_q.delete();
      mlevel = 0;
    end else begin
      all_diff = 1;
      for (int j = 2; j <= int'(Deb) + 1; j++) begin
        s2v = (raw_h.size() >= j) ? raw_h[raw_h.size() - j] : 1'b0;
        if (s2v == mlevel) all_diff = 0;
      end
      code2 = (code_h.size() >= 2) ? code_h[code_h.size() - 2] : 2'b00;
      mfull = (mq.size() == 2);
      mpop  = coin_ack && (mq.size() > 0);
      if (mpop) void'(mq.pop_front());
      if (all_diff) begin
        mlevel = !mlevel;
        if (mlevel) begin
          if (code2 == 2'b00 || (mfull && !mpop)) begin
            exp_rej_q.push_back(edge_n);
          end else begin
            mq.push_back(coin_value(code2));
            exp_coin_q.push_back(coin_value(code2));
          end
        end
      end
      raw_h.push_back(sense);
      code_h.push_back(size_code);
      if (raw_h.size() > 12) begin
        void'(raw_h.pop_front());
        void'(code_h.pop_front());
      end
    end
  end

  // Monitor: per-cycle output check plus scoreboard pops on reject pulses and acked coins.
  always @(negedge clk) begin
    if (started) begin
      chk("fill", int'(fill), mq.size());
      chk("c", int'(c), (mq.size() != 0) ? 1 : 0);
      chk("a", int'(a), (mq.size() != 0) ? mq[0] : 0);
      if (reject) begin
        if (exp_rej_q.size() == 0) chk("reject_unexpected", 1, 0);
        else                       chk("reject_edge", edge_n, exp_rej_q.pop_front());
      end else if (exp_rej_q.size() > 0 && exp_rej_q[0] <= edge_n) begin
        chk("reject_missing", 0, 1);
        void'(exp_rej_q.pop_front());
      end
      if (c && coin_ack && !rst) begin
        if (exp_coin_q.size() == 0) chk("ack_unexpected", 1, 0);
        else                        chk("acked_value", int'(a), exp_coin_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle();
    coin_ack = ($urandom_range(0, 3) == 0);
    rst      = ($urandom_range(0, 399) == 0);
    step(1);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] cd, input int hi, input int lo);
    size_code = cd;
    sense     = 1'b1;
    step(hi);
    sense = 1'b0;
    step(lo);
  endtask

  initial begin
    rst       = 1'b1;
    sense     = 1'b0;
    size_code = 2'b00;
    coin_ack  = 1'b0;
    step(3);
    started = 1;
    rst     = 1'b0;

    // Too-short pulse is ignored.
    pulse(2'b10, 3, 10);
    chk("short_c", int'(c), 0);
    chk("short_fill", int'(fill), 0);

    // Single dime: visible after edge k+5, held until acked.
    size_code = 2'b10;
    sense     = 1'b1;
    step(5);
    chk("dime_early_c", int'(c), 0);
    step(1);
    chk("dime_c", int'(c), 1);
    chk("dime_a", int'(a), 10);
    step(6);
    sense = 1'b0;
    step(6);
    chk("dime_held_a", int'(a), 10);
    coin_ack = 1'b1;
    step(1);
    coin_ack = 1'b0;
    chk("dime_acked_c", int'(c), 0);
    chk("dime_acked_a", int'(a), 0);
    chk("dime_acked_fill", int'(fill), 0);

    // Three quarters with no ack: third is rejected.
    repeat (3) pulse(2'b11, 10, 10);
    chk("qq_fill", int'(fill), 2);
    chk("qq_a", int'(a), 25);
    coin_ack = 1'b1;
    step(1);
    chk("qq_ack1_fill", int'(fill), 1);
    step(1);
    chk("qq_ack2_fill", int'(fill), 0);
    coin_ack = 1'b0;

    // Invalid size code.
    pulse(2'b00, 10, 10);
    chk("invalid_c", int'(c), 0);

    // Enqueue and pop on the same edge.
    pulse(2'b01, 12, 8);
    chk("nickel_a", int'(a), 5);
    size_code = 2'b10;
    sense     = 1'b1;
    step(5);
    coin_ack = 1'b1;
    step(1);
    coin_ack = 1'b0;
    chk("swap_fill", int'(fill), 1);
    chk("swap_a", int'(a), 10);
    step(6);
    sense = 1'b0;
    step(10);
    coin_ack = 1'b1;
    step(1);
    coin_ack = 1'b0;

    // Reset with a full queue while sense stays high.
    repeat (2) pulse(2'b11, 10, 10);
    chk("prerst_fill", int'(fill), 2);
    sense = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_c", int'(c), 0);
    chk("rst_a", int'(a), 0);
    chk("rst_fill", int'(fill), 0);
    step(12);
    chk("rerun_fill", int'(fill), 1);
    chk("rerun_a", int'(a), 25);
    sense = 1'b0;
    step(10);
    coin_ack = 1'b1;
    step(1);
    coin_ack = 1'b0;

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      size_code = 2'($urandom_range(0, 3));
      sense     = 1'b1;
      for (int h = $urandom_range(1, 14); h > 0; h--) rand_cycle();
      sense = 1'b0;
      for (int l = $urandom_range(1, 14); l > 0; l--) rand_cycle();
    end

    coin_ack = 1'b0;
    sense    = 1'b0;
    step(20);
    chk("pending_rejects", exp_rej_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
